shift_chain_driver: RTL and testbench

Parallel-to-serial feeder for the on-chip serial shift chain. It accepts bytes over a valid/ready handshake and serializes them MSB-first onto the chain's serial-data and clock-enable inputs. It counts bits per DEPTH-bit frame and can pad a partial frame with zeros (flush), so a full chain load completes from bytewise host writes.

---
 rtl/shift_chain_pkg.sv | 14 +
 rtl/shift_chain_piso.sv | 50 +++++
 rtl/shift_chain_driver.sv | 129 ++++++++++++
 tb/tb_shift_chain_driver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_chain_pkg.sv
// Shared constants and state encoding for the shift-chain driver.
package shift_chain_pkg;

    localparam int DEFAULT_DEPTH = 256;
    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/shift_chain_piso.sv
// WIDTH-bit load/shift register with a per-word bit index and last-bit flag.
// SHIFT_CHAIN_LSB_FIRST_EN selects LSB-first output order; default is MSB-first.
module shift_chain_piso
    import shift_chain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    output logic             out_bit,
    output logic             last
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [IDX_W-1:0] idx;

    // The bit on the chain is always taken straight from the register, so it
    // holds its value whenever the register is neither loaded nor shifted.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= load_data;
            idx  <= '0;
        end else if (shift) begin
`ifdef SHIFT_CHAIN_LSB_FIRST_EN
            sreg <= sreg >> 1;
`else
            sreg <= sreg << 1;
`endif
            idx  <= idx + IDX_W'(1);
        end
    end

`ifdef SHIFT_CHAIN_LSB_FIRST_EN
    assign out_bit = sreg[0];
`else
    assign out_bit = sreg[WIDTH-1];
`endif

    assign last = (idx == LAST_IDX);

endmodule

// File: rtl/shift_chain_driver.sv
// Byte-wide valid/ready feeder that serializes words onto the scan chain and
// zero-pads partial DEPTH-bit frames on flush (bit order via SHIFT_CHAIN_LSB_FIRST_EN).
module shift_chain_driver
    import shift_chain_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    output logic                     sd_out,
    output logic                     sd_en,
    output logic [$clog2(DEPTH)-1:0] bit_count,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int BC_W = $clog2(DEPTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DEPTH - 1);

    state_t           state;
    state_t           state_next;
    logic             flush_pending;
    logic             pending_next;
    logic             piso_load;
    logic             piso_shift;
    logic             piso_last;
    logic [WIDTH-1:0] piso_data;
    logic             accept;
    logic             frame_end;

    shift_chain_piso #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (piso_load),
        .load_data (piso_data),
        .shift     (piso_shift),
        .out_bit   (sd_out),
        .last      (piso_last)
    );

    assign frame_end  = (bit_count == LAST_BIT);
    assign in_ready   = !flush_pending && ((state == IDLE) || ((state == SHIFT) && piso_last));
    assign accept     = in_valid && in_ready;
    assign busy       = (state != IDLE);
    assign frame_done = sd_en && frame_end;

    // Padding is produced by loading an all-zero word, so the data path never
    // needs a separate zero mux on the serial output.
    always_comb begin
        state_next   = state;
        pending_next = flush_pending;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;
        piso_data    = '0;
        case (state)
            IDLE: begin
                pending_next = 1'b0;
                if (flush) begin
                    if (bit_count != '0) begin
                        state_next = FLUSH;
                        piso_load  = 1'b1;
                    end
                end else if (accept) begin
                    state_next = SHIFT;
                    piso_load  = 1'b1;
                    piso_data  = in_data;
                end
            end
            SHIFT: begin
                if (flush) begin
                    pending_next = 1'b1;
                end
                if (!piso_last) begin
                    piso_shift = 1'b1;
                end else begin
                    if (frame_end) begin
                        pending_next = 1'b0;
                    end
                    if (accept) begin
                        piso_load  = 1'b1;
                        piso_data  = in_data;
                    end else if (pending_next) begin
                        state_next   = FLUSH;
                        pending_next = 1'b0;
                        piso_load    = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            FLUSH: begin
                pending_next = 1'b0;
                if (frame_end) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                pending_next = 1'b0;
            end
        endcase
    end

    // The strobe is registered from the next state so it lines up with the
    // bit the shift register presents in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            flush_pending <= 1'b0;
            sd_en         <= 1'b0;
            bit_count     <= '0;
        end else begin
            state         <= state_next;
            flush_pending <= pending_next;
            sd_en         <= (state_next != IDLE);
            if (sd_en) begin
                bit_count <= frame_end ? '0 : bit_count + BC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_chain_driver.sv
// Directed bench for shift_chain_driver (DEPTH=256, WIDTH=8); honours SHIFT_CHAIN_LSB_FIRST_EN.
module tb_shift_chain_driver;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       sd_out;
    logic       sd_en;
    logic [7:0] bit_count;
    logic       frame_done;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] tb_words [0:31];

    int   r_en_total;
    int   r_fd_count;
    int   r_fd_pos;
    int   r_bad_bits;
    int   r_pad_bits;
    int   r_ready_in_pad;
    int   r_bubbles;
    logic r_gap_busy;

    shift_chain_driver #(
        .DEPTH (256),
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .sd_out     (sd_out),
        .sd_en      (sd_en),
        .bit_count  (bit_count),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        flush    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Streams n_words from tb_words with valid held, optionally pulsing flush
    // (flush_at >= 0: when bit_count equals it mid-stream; -2: once idle after
    // the last word). The reference stream is the words' bits followed by zeros.
    task automatic apply_stimulus(input int n_words, input int flush_at, input int budget);
        logic q[$];
        int   idx = 0;
        int   first_en = -1;
        int   last_en = -1;
        logic flush_sent = 1'b0;
        logic gap_seen = 1'b0;
        logic exp_bit;
        logic [7:0] w;
        r_en_total = 0; r_fd_count = 0; r_fd_pos = -1; r_bad_bits = 0;
        r_pad_bits = 0; r_ready_in_pad = 0; r_gap_busy = 1'b1;
        for (int c = 0; c < budget; c++) begin
            in_valid = (idx < n_words);
            in_data  = (idx < n_words) ? tb_words[idx] : 8'h00;
            flush    = 1'b0;
            if (!flush_sent &&
                ((flush_at >= 0 && sd_en && bit_count == 8'(flush_at)) ||
                 (flush_at == -2 && idx == n_words && !busy))) begin
                flush      = 1'b1;
                flush_sent = 1'b1;
            end
            if (sd_en) begin
                r_en_total++;
                if (first_en < 0) first_en = c;
                last_en = c;
                if (q.size() > 0) begin
                    exp_bit = q.pop_front();
                end else begin
                    exp_bit = 1'b0;
                    r_pad_bits++;
                    if (in_ready) r_ready_in_pad++;
                end
                if (sd_out !== exp_bit) r_bad_bits++;
            end else if (first_en >= 0 && !gap_seen) begin
                gap_seen   = 1'b1;
                r_gap_busy = busy;
            end
            if (frame_done) begin
                r_fd_count++;
                r_fd_pos = r_en_total;
            end
            if (in_valid && in_ready && !(flush && !busy)) begin
                w = tb_words[idx];
`ifdef SHIFT_CHAIN_LSB_FIRST_EN
                for (int b = 0; b < 8; b++) q.push_back(w[b]);
`else
                for (int b = 7; b >= 0; b--) q.push_back(w[b]);
`endif
                idx++;
            end
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        r_bubbles = (first_en < 0) ? 0 : (last_en - first_en + 1 - r_en_total);
    endtask

    initial begin
        logic [7:0] seq_c1;
        int         fd_seen;
`ifdef SHIFT_CHAIN_LSB_FIRST_EN
        seq_c1 = 8'b1000_0011;
`else
        seq_c1 = 8'b1100_0001;
`endif
        for (int i = 0; i < 32; i++) tb_words[i] = 8'(i * 37 + 5);

        // Reset state
        apply_reset();
        check_output("reset_sd_en", sd_en, 0);
        check_output("reset_sd_out", sd_out, 0);
        check_output("reset_bit_count", bit_count, 0);
        check_output("reset_frame_done", frame_done, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_in_ready", in_ready, 1);

        // Single word 0xC1
        in_data  = 8'hC1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        fd_seen  = 0;
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("c1_sd_en_%0d", i), sd_en, 1);
            check_output($sformatf("c1_bit_%0d", i), sd_out, seq_c1[7-i]);
            check_output($sformatf("c1_count_%0d", i), bit_count, i);
            check_output($sformatf("c1_ready_%0d", i), in_ready, (i == 7) ? 1 : 0);
            if (frame_done) fd_seen++;
            tick();
        end
        check_output("c1_sd_en_after", sd_en, 0);
        check_output("c1_count_after", bit_count, 8);
        check_output("c1_busy_after", busy, 0);
        check_output("c1_frame_done_none", fd_seen, 0);

        // 32 back-to-back words: one full frame
        apply_reset();
        apply_stimulus(32, -1, 270);
        check_output("b2b_en_total", r_en_total, 256);
        check_output("b2b_bubbles", r_bubbles, 0);
        check_output("b2b_bad_bits", r_bad_bits, 0);
        check_output("b2b_pad_bits", r_pad_bits, 0);
        check_output("b2b_fd_count", r_fd_count, 1);
        check_output("b2b_fd_pos", r_fd_pos, 256);
        check_output("b2b_busy_after_last", r_gap_busy, 0);
        check_output("b2b_count_wrap", bit_count, 0);

        // 3 words then flush from IDLE
        apply_reset();
        apply_stimulus(3, -2, 280);
        check_output("fl_idle_en_total", r_en_total, 256);
        check_output("fl_idle_pad_bits", r_pad_bits, 232);
        check_output("fl_idle_bad_bits", r_bad_bits, 0);
        check_output("fl_idle_fd_count", r_fd_count, 1);
        check_output("fl_idle_fd_pos", r_fd_pos, 256);
        check_output("fl_idle_ready_in_pad", r_ready_in_pad, 0);
        check_output("fl_idle_bubbles", r_bubbles, 1);
        check_output("fl_idle_count", bit_count, 0);

        // Flush at bit_count 0, alone and together with in_valid
        apply_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("fl_zero_sd_en", sd_en, 0);
        check_output("fl_zero_busy", busy, 0);
        tick();
        check_output("fl_zero_sd_en2", sd_en, 0);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check_output("fl_valid_sd_en", sd_en, 0);
        check_output("fl_valid_busy", busy, 0);
        check_output("fl_valid_count", bit_count, 0);

        // Flush mid-word 2 at bit 3; word 3 must wait until padding ends
        apply_reset();
        apply_stimulus(3, 11, 300);
        check_output("fl_mid_en_total", r_en_total, 264);
        check_output("fl_mid_pad_bits", r_pad_bits, 240);
        check_output("fl_mid_bad_bits", r_bad_bits, 0);
        check_output("fl_mid_fd_count", r_fd_count, 1);
        check_output("fl_mid_ready_in_pad", r_ready_in_pad, 0);
        check_output("fl_mid_bubbles", r_bubbles, 1);
        check_output("fl_mid_count", bit_count, 8);

        // Reset on bit 4 of a word, then a fresh 0xFF
        apply_reset();
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check_output("rst_mid_count_before", bit_count, 4);
        check_output("rst_mid_sd_en_before", sd_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("rst_mid_sd_en", sd_en, 0);
        check_output("rst_mid_count", bit_count, 0);
        check_output("rst_mid_busy", busy, 0);
        tick();
        check_output("rst_mid_sd_en_later", sd_en, 0);
        tb_words[0] = 8'hFF;
        apply_stimulus(1, -1, 20);
        check_output("ff_en_total", r_en_total, 8);
        check_output("ff_bad_bits", r_bad_bits, 0);
        check_output("ff_fd_count", r_fd_count, 0);
        check_output("ff_count", bit_count, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
